ibus_cbus_bridge: RTL and testbench

//   Instruction-bus responder: answers fetch-stage ibus requests by issuing single-beat

---
 rtl/ibus_cbus_bridge.sv | 86 ++++++++
 tb/tb_ibus_cbus_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ibus_cbus_bridge.sv
// Instruction-bus responder: turns each accepted fetch into one single-beat cbus read
// and returns the word to decode, discarding the result if the pipeline flushes meanwhile.
module ibus_cbus_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  input  logic              flush,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [DATA_W-1:0] iresp_data,
  output logic              creq_valid,
  output logic [ADDR_W-1:0] creq_addr,
  output logic              creq_is_write,
  output logic [2:0]        creq_size,
  output logic [3:0]        creq_len,
  input  logic              cresp_ready,
  input  logic              cresp_last,
  input  logic [DATA_W-1:0] cresp_data
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    addr_d        = addr_q;
    data_d        = data_q;
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    creq_valid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        iresp_addr_ok = ireq_valid & ~flush;
        if (ireq_valid && !flush) begin
          addr_d  = ireq_addr;
          state_d = StReq;
        end
      end
      StReq: begin
        // The cbus transaction always completes; a flush only marks the result as dead.
        creq_valid = 1'b1;
        if (flush) drop_d = 1'b1;
        if (cresp_ready && cresp_last) begin
          data_d = cresp_data;
          drop_d = 1'b0;
          state_d = (drop_q || flush) ? StIdle : StResp;
        end
      end
      StResp: begin
        iresp_data_ok = ~flush;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign iresp_data    = data_q;
  assign creq_addr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign creq_is_write = 1'b0;
  assign creq_size     = 3'b010;
  assign creq_len      = 4'b0000;

endmodule

// File: tb/tb_ibus_cbus_bridge.sv
// Self-checking bench for ibus_cbus_bridge: planned fetches with random waits, stray beats
// and flushes; expected words go into queues that a negedge monitor pops and compares.
module tb_ibus_cbus_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        flush;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        creq_valid;
  logic [31:0] creq_addr;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [3:0]  creq_len;
  logic        cresp_ready;
  logic        cresp_last;
  logic [31:0] cresp_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_data[$];
  logic [31:0] exp_creq[$];

  always #5 clk = ~clk;

  ibus_cbus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .flush        (flush),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .creq_valid   (creq_valid),
    .creq_addr    (creq_addr),
    .creq_is_write(creq_is_write),
    .creq_size    (creq_size),
    .creq_len     (creq_len),
    .cresp_ready  (cresp_ready),
    .cresp_last   (cresp_last),
    .cresp_data   (cresp_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks cbus requests and delivered words against the queued expectations.
  always @(negedge clk) begin
    if (resetn) begin
      if (creq_valid) begin
        if (exp_creq.size() == 0) begin
          chk("creq_unexpected", 32'd1, 32'd0);
        end else begin
          chk("creq_addr", creq_addr, exp_creq[0]);
          chk("creq_attr", {27'd0, creq_is_write, creq_size, creq_len}, {27'd0, 1'b0, 3'b010, 4'b0000});
          if (cresp_ready && cresp_last) void'(exp_creq.pop_front());
        end
      end
      if (iresp_data_ok) begin
        if (exp_data.size() == 0) chk("data_ok_unexpected", 32'd1, 32'd0);
        else chk("iresp_data", iresp_data, exp_data.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flush_at: -1 none, 0..w a REQ cycle (w is the last-beat cycle), w+1 the RESP cycle.
  // The word is delivered only if no flush hits between accept and the response cycle.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input int w,
                         input int flush_at, input bit rej, input bit hold);
    if (rej) begin
      ireq_valid = 1'b1; ireq_addr = $urandom; flush = 1'b1;
      @(negedge clk);
      chk("reject_with_flush", {31'd0, iresp_addr_ok}, 32'd0);
      step();
    end
    ireq_valid = 1'b1; ireq_addr = a; flush = 1'b0; cresp_ready = 1'b0; cresp_last = 1'b0;
    exp_creq.push_back({a[31:2], 2'b00});
    if (flush_at < 0) exp_data.push_back(d);
    @(negedge clk);
    chk("accept", {31'd0, iresp_addr_ok}, 32'd1);
    step();
    for (int i = 0; i <= w; i++) begin
      ireq_valid = hold; ireq_addr = $urandom; flush = (flush_at == i);
      if (i < w) begin
        cresp_ready = 1'($urandom_range(0, 1)); cresp_last = 1'b0; cresp_data = $urandom;
      end else begin
        cresp_ready = 1'b1; cresp_last = 1'b1; cresp_data = d;
      end
      @(negedge clk);
      chk("req_addr_ok", {31'd0, iresp_addr_ok}, 32'd0);
      chk("req_creq_valid", {31'd0, creq_valid}, 32'd1);
      chk("req_data_ok", {31'd0, iresp_data_ok}, 32'd0);
      step();
    end
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = $urandom;
    if (flush_at < 0 || flush_at == w + 1) begin
      ireq_valid = hold; flush = (flush_at == w + 1);
      @(negedge clk);
      chk("resp_data_ok", {31'd0, iresp_data_ok}, {31'd0, flush_at < 0});
      chk("resp_addr_ok", {31'd0, iresp_addr_ok}, 32'd0);
      chk("resp_creq_valid", {31'd0, creq_valid}, 32'd0);
      step();
    end
    flush = 1'b0; ireq_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; ireq_valid = 1'b0; ireq_addr = '0; flush = 1'b0;
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = '0;
    #3;
    chk("reset_outputs", {28'd0, iresp_addr_ok, iresp_data_ok, creq_valid, 1'b0}, 32'd0);
    chk("reset_creq_addr", creq_addr, 32'd0);
    chk("reset_iresp_data", iresp_data, 32'd0);
    step(); step();
    resetn = 1'b1;
    step();

    run_txn(32'hBFC0_0000, 32'h2408_0001, 2, -1, 1'b0, 1'b0);   // single fetch
    run_txn(32'h0000_1000, 32'hCAFE_F00D, 0, -1, 1'b0, 1'b0);   // zero-wait memory
    run_txn(32'h0000_2000, 32'h1234_5678, 2, 0, 1'b0, 1'b0);    // flush in REQ
    run_txn(32'h0000_3004, 32'h0BAD_BEEF, 1, 2, 1'b0, 1'b0);    // flush in RESP
    run_txn(32'h0000_0000, 32'h1111_1111, 1, -1, 1'b0, 1'b1);   // back-to-back, valid held
    run_txn(32'h0000_0004, 32'h2222_2222, 0, -1, 1'b1, 1'b1);   // accept+flush rejected first
    run_txn(32'h0000_4007, 32'h3333_3333, 0, -1, 1'b0, 1'b0);   // low addr bits cleared

    for (int t = 0; t < 80; t++) begin
      int w;
      int fa;
      w  = $urandom_range(0, 3);
      fa = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, w + 1));
      run_txn($urandom, $urandom, w, fa, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    // Async reset while a cbus read is outstanding.
    ireq_valid = 1'b1; ireq_addr = 32'h8000_0010;
    exp_creq.push_back(32'h8000_0010);
    @(negedge clk);
    chk("rst_test_accept", {31'd0, iresp_addr_ok}, 32'd1);
    step();
    ireq_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_reset_outputs", {29'd0, iresp_addr_ok, iresp_data_ok, creq_valid}, 32'd0);
    chk("async_reset_creq_addr", creq_addr, 32'd0);
    chk("async_reset_iresp_data", iresp_data, 32'd0);
    exp_creq.delete();
    step();
    resetn = 1'b1;
    step();
    run_txn(32'h0000_5000, 32'h4444_4444, 1, -1, 1'b0, 1'b0);

    step();
    chk("exp_data_drained", exp_data.size(), 32'd0);
    chk("exp_creq_drained", exp_creq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
